// File: rtl/hh_stdp_pkg.sv
// Shared types and constants for the HH/STDP neuron pair and its observers.
package hh_stdp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StReport
  } state_e;

  localparam int unsigned CntWDefault = 8;
  localparam int unsigned WinWDefault = 8;

  // All-ones value of a counter of the given width, capped at 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter
  import hh_stdp_pkg::*;
#(
  parameter int unsigned W = CntWDefault
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] Max = W'(sat_max(W));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (inc && (value != Max)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/spike_window_monitor.sv
// Counts pre, post and causal (post within LAG_WIN cycles of a pre) spikes over a
// programmable window and reports the totals on a valid/ready output.
module spike_window_monitor
  import hh_stdp_pkg::*;
#(
  parameter int unsigned WIN_W   = WinWDefault,
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned LAG_WIN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_pre,
  input  logic             spike_post,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] rate_pre,
  output logic [CNT_W-1:0] rate_post,
  output logic [CNT_W-1:0] causal_cnt
);

  localparam int unsigned      LagW    = $clog2(LAG_WIN + 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(sat_max(CNT_W));
  localparam logic [LagW-1:0]  LagLoad = LagW'(LAG_WIN);

  state_e           state_q;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] tick_q;
  logic [LagW-1:0]  lag_q;

  logic [CNT_W-1:0] pre_run, post_run, causal_run;
  logic [CNT_W-1:0] pre_fin, post_fin, causal_fin;
  logic             counting, clear_cnt, causal_hit, last_tick;

  always_comb begin
    counting   = (state_q == StCount);
    clear_cnt  = (state_q == StIdle) && start && (window_len != '0);
    causal_hit = counting && spike_post && ((lag_q != '0) || spike_pre);
    last_tick  = counting && (tick_q == len_q - WIN_W'(1));
    // Totals including the closing cycle's spikes, which the counters only see next edge.
    pre_fin    = (spike_pre && (pre_run != CntMax)) ? pre_run + CNT_W'(1) : pre_run;
    post_fin   = (spike_post && (post_run != CntMax)) ? post_run + CNT_W'(1) : post_run;
    causal_fin = (causal_hit && (causal_run != CntMax)) ? causal_run + CNT_W'(1) : causal_run;
  end

  sat_counter #(.W(CNT_W)) u_pre_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (counting && spike_pre),
    .value (pre_run)
  );

  sat_counter #(.W(CNT_W)) u_post_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (counting && spike_post),
    .value (post_run)
  );

  sat_counter #(.W(CNT_W)) u_causal_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (causal_hit),
    .value (causal_run)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      tick_q     <= '0;
      lag_q      <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      rate_pre   <= '0;
      rate_post  <= '0;
      causal_cnt <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clear_cnt) begin
            len_q   <= window_len;
            tick_q  <= '0;
            lag_q   <= '0;
            busy    <= 1'b1;
            state_q <= StCount;
          end
        end
        StCount: begin
          if (spike_pre) begin
            lag_q <= LagLoad;
          end else if (lag_q != '0) begin
            lag_q <= lag_q - LagW'(1);
          end
          tick_q <= tick_q + WIN_W'(1);
          if (last_tick) begin
            rate_pre   <= pre_fin;
            rate_post  <= post_fin;
            causal_cnt <= causal_fin;
            out_valid  <= 1'b1;
            state_q    <= StReport;
          end
        end
        StReport: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_window_monitor.sv
// Scoreboard bench: a window-level reference model predicts each report; a monitor checks it.
module tb_spike_window_monitor;

  localparam int unsigned WinW   = 8;
  localparam int unsigned CntW   = 4;
  localparam int          LagWin = 16;
  localparam int          CntTop = 15;

  logic            clk = 1'b0;
  logic            reset, spike_pre, spike_post, start, out_ready;
  logic [WinW-1:0] window_len;
  logic            busy, out_valid;
  logic [CntW-1:0] rate_pre, rate_post, causal_cnt;

  typedef struct {
    int pre;
    int post;
    int causal;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  spike_window_monitor #(
    .WIN_W   (WinW),
    .CNT_W   (CntW),
    .LAG_WIN (LagWin)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_pre  (spike_pre),
    .spike_post (spike_post),
    .start      (start),
    .window_len (window_len),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rate_pre   (rate_pre),
    .rate_post  (rate_post),
    .causal_cnt (causal_cnt)
  );

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Counts from the event lists: a post is causal if any pre lies in [k-LagWin, k].
  function automatic exp_t model(int len, logic [63:0] pre, logic [63:0] post);
    exp_t e;
    int np = 0, nq = 0, nc = 0;
    for (int k = 0; k < len; k++) begin
      if (pre[k]) np++;
      if (post[k]) begin
        bit hit = 1'b0;
        nq++;
        for (int j = k - LagWin; j <= k; j++) begin
          if (j >= 0 && pre[j]) hit = 1'b1;
        end
        if (hit) nc++;
      end
    end
    e.pre    = (np > CntTop) ? CntTop : np;
    e.post   = (nq > CntTop) ? CntTop : nq;
    e.causal = (nc > CntTop) ? CntTop : nc;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report: got a report, expected none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rate_pre", int'(rate_pre), e.pre);
        chk("rate_post", int'(rate_post), e.post);
        chk("causal_cnt", int'(causal_cnt), e.causal);
        chk("causal_le_post", int'(causal_cnt <= rate_post), 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_window(int len, logic [63:0] pre, logic [63:0] post, int delay,
                            bit start_in_report);
    exp_t e = model(len, pre, post);
    exp_q.push_back(e);
    out_ready  = (delay == 0);
    start      = 1'b1;
    window_len = WinW'(len);
    step();
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      spike_pre  = pre[i];
      spike_post = post[i];
      if (i == 0) chk("busy_in_count", int'(busy), 1);
      if (i == len - 1) chk("valid_not_early", int'(out_valid), 0);
      step();
    end
    spike_pre  = 1'b0;
    spike_post = 1'b0;
    chk("valid_rise", int'(out_valid), 1);
    for (int d = 0; d < delay; d++) begin
      start      = start_in_report;
      spike_pre  = 1'b1;
      spike_post = 1'b1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_pre", int'(rate_pre), e.pre);
      chk("hold_causal", int'(causal_cnt), e.causal);
      step();
    end
    spike_pre  = 1'b0;
    spike_post = 1'b0;
    out_ready  = 1'b1;
    start      = start_in_report;
    step();
    start = 1'b0;
    chk("valid_drop", int'(out_valid), 0);
    chk("idle_after_xfer", int'(busy), 0);
    chk("kept_pre", int'(rate_pre), e.pre);
    chk("kept_post", int'(rate_post), e.post);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rp, rq;
    int          len, pd, qd;
    reset      = 1'b1;
    spike_pre  = 1'b0;
    spike_post = 1'b0;
    start      = 1'b0;
    window_len = '0;
    out_ready  = 1'b1;
    step();
    step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_pre", int'(rate_pre), 0);
    chk("reset_causal", int'(causal_cnt), 0);
    reset = 1'b0;
    step();

    // Rate only, lag edge, saturation, backpressure with start during REPORT.
    run_window(10, 64'h11, 64'h0, 0, 1'b0);
    run_window(25, 64'h2, 64'h6_0002, 0, 1'b0);
    run_window(40, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1'b0);
    run_window(12, 64'h0A5, 64'h3C6, 5, 1'b1);

    // Reset in window cycle 4 of 10 discards everything.
    out_ready  = 1'b1;
    start      = 1'b1;
    window_len = 8'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spike_pre  = 1'b1;
      spike_post = 1'b1;
      if (i == 3) reset = 1'b1;
      step();
    end
    reset      = 1'b0;
    spike_pre  = 1'b0;
    spike_post = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_pre", int'(rate_pre), 0);
    chk("abort_post", int'(rate_post), 0);
    repeat (3) step();
    chk("abort_stays_idle", int'(busy), 0);
    run_window(10, 64'h201, 64'h30C, 2, 1'b0);

    // Zero-length start ignored; spikes in IDLE ignored.
    start      = 1'b1;
    window_len = 8'd0;
    step();
    start = 1'b0;
    chk("zero_len_busy", int'(busy), 0);
    step();
    chk("zero_len_busy2", int'(busy), 0);
    spike_pre  = 1'b1;
    spike_post = 1'b1;
    repeat (5) step();
    spike_pre  = 1'b0;
    spike_post = 1'b0;
    run_window(3, 64'h0, 64'h0, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      len = $urandom_range(60, 1);
      pd  = $urandom_range(9, 2);
      qd  = $urandom_range(6, 1);
      rp  = '0;
      rq  = '0;
      for (int i = 0; i < 64; i++) begin
        rp[i] = ($urandom_range(pd, 0) == 0);
        rq[i] = ($urandom_range(qd, 0) == 0);
      end
      run_window(len, rp, rq, $urandom_range(4, 0), 1'($urandom_range(1, 0)));
    end

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
